eth_arp_responder: RTL and testbench



---
 rtl/eth_arp_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_eth_arp_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_arp_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eth_arp_responder
// Brief    : Parses GMII RX for ARP requests to LOCAL_IP and emits a full
//            ARP reply frame (preamble, padding, FCS) on GMII TX.
// Revision : 1.0 - initial release
// ============================================================================
module eth_arp_responder #(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_07_ed_ac_62_00,
    parameter logic [31:0] LOCAL_IP   = 32'hc0_a8_00_02,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk_125m,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rxdv,
    input  logic        tx_gnt,
    output logic        tx_req,
    output logic [7:0]  gmii_txd,
    output logic        gmii_txen,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        arp_req_seen,
    output logic        arp_drop,
    output logic [47:0] exter_mac,
    output logic [31:0] exter_ip
);

    // The CRC register shifts LSB-first, so the good-frame residue 0xC704DD7B
    // appears here in bit-reversed form.
    localparam logic [31:0] c_crc_init    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_crc_residue = 32'hDEBB_20E3;
    localparam logic [79:0] c_rx_hdr      = {16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001};
    localparam logic [10:0] c_idx_max     = 11'd2047;
    localparam logic [15:0] c_ifg_last    = 16'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PRE  = 2'd1,
        R_DATA = 2'd2,
        R_WAIT = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE = 3'd0,
        T_REQ  = 3'd1,
        T_PRE  = 3'd2,
        T_DATA = 3'd3,
        T_FCS  = 3'd4,
        T_IFG  = 3'd5
    } tx_state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] x;
        x = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        end
        return x;
    endfunction

    rx_state_t   r_rx_state, w_rx_next;
    tx_state_t   r_tx_state, w_tx_next;
    logic [10:0] r_idx;
    logic [31:0] r_rx_crc, r_tx_crc;
    logic        r_fields_ok, r_dst_bc, r_dst_uc;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic [15:0] r_tx_cnt, w_tx_cnt_next;
    logic        w_chk_en;
    logic [7:0]  w_chk_byte, w_dst_byte, w_txd_next;
    logic        w_rx_valid, w_tx_idle, w_accept;
    logic [335:0] w_tx_hdr;

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) r_rx_state <= R_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE: if (gmii_rxdv && gmii_rxd == 8'h55) w_rx_next = R_PRE;
            R_PRE: begin
                if (!gmii_rxdv)              w_rx_next = R_IDLE;
                else if (gmii_rxd == 8'hD5)  w_rx_next = R_DATA;
                else if (gmii_rxd != 8'h55)  w_rx_next = R_WAIT;
            end
            R_DATA:  if (!gmii_rxdv) w_rx_next = R_IDLE;
            R_WAIT:  if (!gmii_rxdv) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // Expected byte for the fixed header fields and the target protocol address
    always_comb begin
        w_chk_en   = 1'b0;
        w_chk_byte = 8'h00;
        w_dst_byte = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (r_idx == 11'(i)) w_dst_byte = LOCAL_MAC[8*(5-i) +: 8];
        end
        for (int i = 0; i < 10; i++) begin
            if (r_idx == 11'(12 + i)) begin
                w_chk_en   = 1'b1;
                w_chk_byte = c_rx_hdr[8*(9-i) +: 8];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (r_idx == 11'(38 + i)) begin
                w_chk_en   = 1'b1;
                w_chk_byte = LOCAL_IP[8*(3-i) +: 8];
            end
        end
    end

    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_rx_crc    <= c_crc_init;
            r_fields_ok <= 1'b0;
            r_dst_bc    <= 1'b0;
            r_dst_uc    <= 1'b0;
            r_sha       <= '0;
            r_spa       <= '0;
        end else if (r_rx_state == R_PRE && w_rx_next == R_DATA) begin
            r_idx       <= '0;
            r_rx_crc    <= c_crc_init;
            r_fields_ok <= 1'b1;
            r_dst_bc    <= 1'b1;
            r_dst_uc    <= 1'b1;
        end else if (r_rx_state == R_DATA && gmii_rxdv) begin
            r_rx_crc <= crc32_byte(r_rx_crc, gmii_rxd);
            if (r_idx != c_idx_max) r_idx <= r_idx + 11'd1;
            if (w_chk_en && gmii_rxd != w_chk_byte) r_fields_ok <= 1'b0;
            if (r_idx < 11'd6) begin
                if (gmii_rxd != 8'hFF)       r_dst_bc <= 1'b0;
                if (gmii_rxd != w_dst_byte)  r_dst_uc <= 1'b0;
            end
            if (r_idx >= 11'd22 && r_idx <= 11'd27) r_sha <= {r_sha[39:0], gmii_rxd};
            if (r_idx >= 11'd28 && r_idx <= 11'd31) r_spa <= {r_spa[23:0], gmii_rxd};
        end
    end

    assign w_rx_valid = (r_rx_state == R_DATA) && !gmii_rxdv && r_fields_ok &&
                        (r_dst_bc || r_dst_uc) && (r_idx >= 11'd64) &&
                        (r_rx_crc == c_crc_residue);
    assign w_tx_idle  = (r_tx_state == T_IDLE);
    assign w_accept   = w_rx_valid && w_tx_idle;

    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            arp_req_seen <= 1'b0;
            arp_drop     <= 1'b0;
            exter_mac    <= '0;
            exter_ip     <= '0;
        end else begin
            arp_req_seen <= w_accept;
            arp_drop     <= w_rx_valid && !w_tx_idle;
            if (w_accept) begin
                exter_mac <= r_sha;
                exter_ip  <= r_spa;
            end
        end
    end

    // ---------------- TX FSM ----------------
    assign w_tx_hdr = {exter_mac, LOCAL_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                       16'h0002, LOCAL_MAC, LOCAL_IP, exter_mac, exter_ip};

    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= w_tx_cnt_next;
        end
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_cnt_next = r_tx_cnt + 16'd1;
        case (r_tx_state)
            T_IDLE: begin
                w_tx_cnt_next = '0;
                if (w_accept) w_tx_next = T_REQ;
            end
            T_REQ: begin
                w_tx_cnt_next = '0;
                if (tx_gnt) w_tx_next = T_PRE;
            end
            T_PRE: if (r_tx_cnt == 16'd7) begin
                w_tx_next = T_DATA; w_tx_cnt_next = '0;
            end
            T_DATA: if (r_tx_cnt == 16'd59) begin
                w_tx_next = T_FCS; w_tx_cnt_next = '0;
            end
            T_FCS: if (r_tx_cnt == 16'd3) begin
                w_tx_next = T_IFG; w_tx_cnt_next = '0;
            end
            T_IFG: if (r_tx_cnt == c_ifg_last) begin
                w_tx_next = T_IDLE; w_tx_cnt_next = '0;
            end
            default: begin
                w_tx_next = T_IDLE; w_tx_cnt_next = '0;
            end
        endcase
    end

    // Byte for the upcoming cycle; outputs are registered from the next state
    always_comb begin
        w_txd_next = 8'h00;
        case (w_tx_next)
            T_PRE:  w_txd_next = (w_tx_cnt_next == 16'd7) ? 8'hD5 : 8'h55;
            T_DATA: begin
                for (int i = 0; i < 42; i++) begin
                    if (w_tx_cnt_next == 16'(i)) w_txd_next = w_tx_hdr[8*(41-i) +: 8];
                end
            end
            T_FCS: begin
                for (int i = 0; i < 4; i++) begin
                    if (w_tx_cnt_next == 16'(i)) w_txd_next = ~r_tx_crc[8*i +: 8];
                end
            end
            default: w_txd_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            tx_req    <= 1'b0;
            gmii_txen <= 1'b0;
            gmii_txd  <= 8'h00;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            r_tx_crc  <= c_crc_init;
        end else begin
            tx_req    <= (w_tx_next == T_REQ);
            gmii_txen <= (w_tx_next == T_PRE) || (w_tx_next == T_DATA) || (w_tx_next == T_FCS);
            gmii_txd  <= w_txd_next;
            tx_busy   <= (w_tx_next != T_IDLE);
            tx_done   <= (w_tx_next == T_IFG) && (w_tx_cnt_next == c_ifg_last);
            if (w_tx_next == T_PRE)       r_tx_crc <= c_crc_init;
            else if (w_tx_next == T_DATA) r_tx_crc <= crc32_byte(r_tx_crc, w_txd_next);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_arp_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_arp_responder
// Brief    : Scoreboard bench for eth_arp_responder: directed ARP frames,
//            expected reply bytes and exter_* values queued, checked by monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_arp_responder;

    localparam logic [47:0] c_local_mac = 48'h0007_edac_6200;
    localparam logic [31:0] c_local_ip  = 32'hc0a8_0002;
    localparam logic [47:0] c_bcast     = 48'hffff_ffff_ffff;
    localparam logic [47:0] c_sha_a     = 48'h1122_3344_5566;
    localparam logic [47:0] c_sha_b     = 48'haabb_ccdd_eeff;
    localparam logic [47:0] c_sha_d     = 48'h0a0b_0c0d_0e0f;
    localparam logic [47:0] c_sha_e     = 48'h6655_4433_2211;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        rxdv = 1'b0;
    logic        tx_gnt = 1'b1;
    logic        tx_req, gmii_txen, tx_busy, tx_done, arp_req_seen, arp_drop;
    logic [7:0]  gmii_txd;
    logic [47:0] exter_mac;
    logic [31:0] exter_ip;

    int total = 0;
    int bad = 0;
    int drop_cnt = 0;
    int done_cnt = 0;
    logic [7:0]  exp_tx[$];
    logic [79:0] exp_seen[$];
    logic [7:0]  frm[$];

    eth_arp_responder dut (
        .clk_125m     (clk),
        .rst          (rst),
        .gmii_rxd     (rxd),
        .gmii_rxdv    (rxdv),
        .tx_gnt       (tx_gnt),
        .tx_req       (tx_req),
        .gmii_txd     (gmii_txd),
        .gmii_txen    (gmii_txen),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .arp_req_seen (arp_req_seen),
        .arp_drop     (arp_drop),
        .exter_mac    (exter_mac),
        .exter_ip     (exter_ip)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ethernet CRC-32 computed MSB-first on the normal polynomial, then reflected
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hffff_ffff;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ q[k][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04c1_1db7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    task automatic put(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    task automatic push_reply(input logic [47:0] mac, input logic [31:0] ip);
        logic [31:0] fcs;
        frm.delete();
        put(64'(mac), 6); put(64'(c_local_mac), 6);
        put(64'h0806, 2); put(64'h0001, 2); put(64'h0800, 2);
        put(64'h06, 1); put(64'h04, 1); put(64'h0002, 2);
        put(64'(c_local_mac), 6); put(64'(c_local_ip), 4);
        put(64'(mac), 6); put(64'(ip), 4);
        repeat (18) frm.push_back(8'h00);
        fcs = fcs_of(frm);
        repeat (7) exp_tx.push_back(8'h55);
        exp_tx.push_back(8'hd5);
        foreach (frm[k]) exp_tx.push_back(frm[k]);
        for (int i = 0; i < 4; i++) exp_tx.push_back(fcs[8*i +: 8]);
        exp_seen.push_back({mac, ip});
    endtask

    task automatic build_req(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input logic [15:0] etype, input logic [15:0] oper,
                             input int pad, input int flip);
        logic [31:0] fcs;
        frm.delete();
        put(64'(dst), 6); put(64'(sha), 6); put(64'(etype), 2);
        put(64'h0001, 2); put(64'h0800, 2); put(64'h06, 1); put(64'h04, 1);
        put(64'(oper), 2); put(64'(sha), 6); put(64'(spa), 4);
        put(64'h0, 6); put(64'(tpa), 4);
        repeat (pad) frm.push_back(8'h00);
        fcs = fcs_of(frm);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (flip >= 0) frm[flip/8] = frm[flip/8] ^ (8'h01 << (flip % 8));
    endtask

    task automatic send_frame();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rxdv = 1'b1;
            rxd  = (i == 7) ? 8'hd5 : 8'h55;
        end
        foreach (frm[k]) begin
            @(posedge clk); #1;
            rxd = frm[k];
        end
        @(posedge clk); #1;
        rxdv = 1'b0;
        rxd  = 8'h00;
    endtask

    // Called right after send_frame returns, i.e. during cycle R, with tx_gnt=1
    task automatic check_timing();
        int n;
        @(negedge clk);
        chk("req_at_R", 80'(tx_req), 80'(0));
        @(negedge clk);
        chk("seen_at_R1", 80'(arp_req_seen), 80'(1));
        chk("req_at_R1", 80'(tx_req), 80'(1));
        chk("busy_at_R1", 80'(tx_busy), 80'(1));
        @(negedge clk);
        chk("txen_at_R2", 80'(gmii_txen), 80'(1));
        n = 0;
        while (gmii_txen && n < 200) begin n++; @(negedge clk); end
        chk("txen_length", 80'(n), 80'(72));
        while (!tx_done && n < 300) begin n++; @(negedge clk); end
        chk("done_offset", 80'(n), 80'(83));
        chk("busy_at_done", 80'(tx_busy), 80'(1));
        @(negedge clk);
        chk("busy_after_done", 80'(tx_busy), 80'(0));
    endtask

    task automatic no_reply(input string name);
        logic quiet;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx_req || arp_req_seen || arp_drop || gmii_txen) quiet = 1'b0;
        end
        chk(name, 80'(quiet), 80'(1));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        if (gmii_txen) begin
            if (exp_tx.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_extra_byte: got txd=%h with txen, expected no transmission", gmii_txd);
            end else begin
                chk("tx_byte", 80'(gmii_txd), 80'(exp_tx.pop_front()));
            end
        end
        if (arp_req_seen) begin
            if (exp_seen.size() == 0) begin
                total++; bad++;
                $display("FAIL seen_extra: got arp_req_seen=1, expected no accepted request");
            end else begin
                chk("exter_on_seen", {exter_mac, exter_ip}, exp_seen.pop_front());
            end
        end
        if (arp_drop) drop_cnt++;
        if (tx_done)  done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    initial begin
        int  n;
        logic ok;

        @(negedge clk);
        chk("reset_outputs", 80'({tx_req, gmii_txen, tx_busy, tx_done, arp_req_seen, arp_drop, gmii_txd}), 80'(0));
        chk("reset_exter", {exter_mac, exter_ip}, 80'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Valid broadcast request, granted immediately
        push_reply(c_sha_a, 32'hc0a80003);
        build_req(c_bcast, c_sha_a, 32'hc0a80003, c_local_ip, 16'h0806, 16'h0001, 18, -1);
        send_frame();
        check_timing();
        chk("exter_after_a", {exter_mac, exter_ip}, {c_sha_a, 32'hc0a80003});

        // Frames that must be ignored
        build_req(c_bcast, c_sha_b, 32'hc0a80004, 32'hc0a80009, 16'h0806, 16'h0001, 18, -1);
        send_frame(); no_reply("ignore_wrong_tpa");
        build_req(c_bcast, c_sha_b, 32'hc0a80004, c_local_ip, 16'h0800, 16'h0001, 18, -1);
        send_frame(); no_reply("ignore_ethertype");
        build_req(c_bcast, c_sha_b, 32'hc0a80004, c_local_ip, 16'h0806, 16'h0002, 18, -1);
        send_frame(); no_reply("ignore_oper_reply");
        build_req(c_bcast, c_sha_b, 32'hc0a80004, c_local_ip, 16'h0806, 16'h0001, 18, 62*8 + 3);
        send_frame(); no_reply("ignore_bad_fcs");
        build_req(c_bcast, c_sha_b, 32'hc0a80004, c_local_ip, 16'h0806, 16'h0001, 14, -1);
        send_frame(); no_reply("ignore_short_frame");
        chk("exter_after_ignored", {exter_mac, exter_ip}, {c_sha_a, 32'hc0a80003});

        // Second request arriving during the reply is dropped
        push_reply(c_sha_a, 32'hc0a80003);
        build_req(c_bcast, c_sha_a, 32'hc0a80003, c_local_ip, 16'h0806, 16'h0001, 18, -1);
        send_frame();
        build_req(c_bcast, c_sha_b, 32'hc0a80006, c_local_ip, 16'h0806, 16'h0001, 18, -1);
        fork
            check_timing();
            send_frame();
        join
        repeat (20) @(negedge clk);
        chk("drop_count", 80'(drop_cnt), 80'(1));
        chk("exter_after_drop", {exter_mac, exter_ip}, {c_sha_a, 32'hc0a80003});

        // Unicast request with the grant withheld for 500 cycles
        tx_gnt = 1'b0;
        push_reply(c_sha_d, 32'hc0a80005);
        build_req(c_local_mac, c_sha_d, 32'hc0a80005, c_local_ip, 16'h0806, 16'h0001, 18, -1);
        send_frame();
        repeat (2) @(negedge clk);
        chk("gnt_wait_req", 80'(tx_req), 80'(1));
        ok = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (!tx_req || gmii_txen) ok = 1'b0;
        end
        chk("gnt_wait_hold", 80'(ok), 80'(1));
        @(posedge clk); #1 tx_gnt = 1'b1;
        @(negedge clk);
        chk("gnt_txen_same_cycle", 80'(gmii_txen), 80'(0));
        @(negedge clk);
        chk("gnt_first_byte", 80'({gmii_txen, gmii_txd}), 80'({1'b1, 8'h55}));
        n = 0;
        while (!tx_done && n < 200) begin n++; @(negedge clk); end
        chk("gnt_reply_done", 80'(tx_done), 80'(1));
        repeat (5) @(negedge clk);

        // Reset during data byte 30 of a reply
        push_reply(c_sha_a, 32'hc0a80003);
        build_req(c_bcast, c_sha_a, 32'hc0a80003, c_local_ip, 16'h0806, 16'h0001, 18, -1);
        send_frame();
        n = 0;
        while (!gmii_txen && n < 50) begin n++; @(negedge clk); end
        chk("rst_test_started", 80'(gmii_txen), 80'(1));
        repeat (38) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_outputs", 80'({tx_req, gmii_txen, tx_busy, tx_done, arp_req_seen, arp_drop, gmii_txd}), 80'(0));
        chk("rst_async_exter", {exter_mac, exter_ip}, 80'(0));
        exp_tx.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        push_reply(c_sha_e, 32'hc0a80007);
        build_req(c_bcast, c_sha_e, 32'hc0a80007, c_local_ip, 16'h0806, 16'h0001, 18, -1);
        send_frame();
        check_timing();

        repeat (20) @(negedge clk);
        chk("tx_queue_drained", 80'(exp_tx.size()), 80'(0));
        chk("seen_queue_drained", 80'(exp_seen.size()), 80'(0));
        chk("done_count", 80'(done_cnt), 80'(4));
        chk("drop_count_final", 80'(drop_cnt), 80'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
